// File: rtl/irq_pkg.sv
// Shared types and helpers for the HuC6280 interrupt-entry sequencer:
// FSM states, taken-source encoding, vector offsets and the priority pick.
package irq_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StPushH,
    StPushL,
    StPushP,
    StVecLo,
    StVecHi,
    StDone,
    StRstLo,
    StRstHi
  } state_e;

  typedef enum logic [2:0] {
    SrcNone  = 3'd0,
    SrcReset = 3'd1,
    SrcNmi   = 3'd2,
    SrcBrk   = 3'd3,
    SrcTiq   = 3'd4,
    SrcIrq1  = 3'd5,
    SrcIrq2  = 3'd6
  } src_e;

  // Low nibble of the vector address, relative to the vector table base.
  localparam logic [3:0] VecOffReset = 4'hE;
  localparam logic [3:0] VecOffNmi   = 4'hC;
  localparam logic [3:0] VecOffTiq   = 4'hA;
  localparam logic [3:0] VecOffIrq1  = 4'h8;
  localparam logic [3:0] VecOffIrq2  = 4'h6;

  // B flag position in the pushed status byte.
  localparam logic [7:0] PMaskB = 8'h10;

  // Fixed priority: NMI, BRK, then the maskable sources gated by P.I.
  function automatic src_e pick_src(
    input logic nmi_pend,
    input logic brk,
    input logic tiq,
    input logic irq1,
    input logic irq2,
    input logic i_flag
  );
    src_e s;
    if (nmi_pend) begin
      s = SrcNmi;
    end else if (brk) begin
      s = SrcBrk;
    end else if (tiq && !i_flag) begin
      s = SrcTiq;
    end else if (irq1 && !i_flag) begin
      s = SrcIrq1;
    end else if (irq2 && !i_flag) begin
      s = SrcIrq2;
    end else begin
      s = SrcNone;
    end
    return s;
  endfunction

  function automatic logic [3:0] vec_offset(input src_e s);
    logic [3:0] off;
    case (s)
      SrcReset: off = VecOffReset;
      SrcNmi:   off = VecOffNmi;
      SrcTiq:   off = VecOffTiq;
      SrcIrq1:  off = VecOffIrq1;
      default:  off = VecOffIrq2;  // IRQ2 and BRK share a vector
    endcase
    return off;
  endfunction

endpackage

// File: rtl/nmi_edge_latch.sv
// Registered falling-edge detector for nmi_n with a sticky pending flag.
// A new edge in the same cycle as clr keeps the flag set.
module nmi_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic nmi_n,
  input  logic clr,
  output logic pend
);

  logic nmi_q;
  logic pend_q;
  logic fall;

  assign fall = nmi_q & ~nmi_n;

  // Runs regardless of bus stalls so no edge is ever lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_q  <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      nmi_q  <= nmi_n;
      pend_q <= fall | (pend_q & ~clr);
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt-entry sequencer: pushes PCH/PCL/P, fetches the vector, loads PC.
// Also performs the post-reset vector fetch. Owns the bus only while busy.
module irq_sequencer
  import irq_pkg::*;
#(
  parameter logic [7:0]  STACK_PAGE = 8'h21,
  parameter logic [15:0] VEC_BASE   = 16'hFFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  input  logic        nmi_n,
  input  logic        tiq,
  input  logic        irq1,
  input  logic        irq2,
  input  logic        brk_req,
  input  logic        boundary,
  input  logic        i_flag,
  input  logic [15:0] pc,
  input  logic [7:0]  p,
  input  logic [7:0]  sp,
  output logic        busy,
  output logic [15:0] bus_addr,
  output logic        bus_re,
  output logic        bus_we,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_new,
  output logic        set_i,
  output logic [2:0]  src
);

  state_e      state_q, state_d;
  src_e        src_q;
  src_e        take_src;
  logic [15:0] pc_q;
  logic [7:0]  p_q;
  logic [7:0]  sp_q;
  logic [7:0]  sp_m1;
  logic [7:0]  sp_m2;
  logic [15:0] vec_q;
  logic [15:0] vec_addr;
  logic        nmi_pend;
  logic        nmi_clr;
  logic        take;

  logic        busy_c;
  logic        we_c;
  logic        re_c;
  logic        sp_dec_c;
  logic        pc_load_c;
  logic        set_i_c;
  logic        cap_lo;
  logic        cap_hi;
  logic [15:0] addr_c;
  logic [7:0]  wdata_c;

  nmi_edge_latch u_nmi_edge_latch (
    .clk   (clk),
    .reset (reset),
    .nmi_n (nmi_n),
    .clr   (nmi_clr),
    .pend  (nmi_pend)
  );

  assign take_src = pick_src(nmi_pend, brk_req, tiq, irq1, irq2, i_flag);
  assign take     = (state_q == StIdle) && boundary && (take_src != SrcNone);
  assign nmi_clr  = take && rdy && (take_src == SrcNmi);

  assign sp_m1    = sp_q - 8'd1;
  assign sp_m2    = sp_q - 8'd2;
  assign vec_addr = VEC_BASE + {12'h000, vec_offset(src_q)};

  always_comb begin
    state_d   = state_q;
    we_c      = 1'b0;
    re_c      = 1'b0;
    sp_dec_c  = 1'b0;
    pc_load_c = 1'b0;
    set_i_c   = 1'b0;
    cap_lo    = 1'b0;
    cap_hi    = 1'b0;
    addr_c    = '0;
    wdata_c   = '0;
    case (state_q)
      StIdle: begin
        if (take) state_d = StPushH;
      end
      StPushH: begin
        we_c     = 1'b1;
        sp_dec_c = 1'b1;
        addr_c   = {STACK_PAGE, sp_q};
        wdata_c  = pc_q[15:8];
        state_d  = StPushL;
      end
      StPushL: begin
        we_c     = 1'b1;
        sp_dec_c = 1'b1;
        addr_c   = {STACK_PAGE, sp_m1};
        wdata_c  = pc_q[7:0];
        state_d  = StPushP;
      end
      StPushP: begin
        we_c     = 1'b1;
        sp_dec_c = 1'b1;
        addr_c   = {STACK_PAGE, sp_m2};
        wdata_c  = p_q;
        state_d  = StVecLo;
      end
      StVecLo, StRstLo: begin
        re_c    = 1'b1;
        cap_lo  = 1'b1;
        addr_c  = vec_addr;
        state_d = (state_q == StRstLo) ? StRstHi : StVecHi;
      end
      StVecHi, StRstHi: begin
        re_c    = 1'b1;
        cap_hi  = 1'b1;
        addr_c  = vec_addr + 16'd1;
        state_d = StDone;
      end
      StDone: begin
        pc_load_c = 1'b1;
        set_i_c   = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StRstLo;
    endcase
  end

  assign busy_c = (state_q != StIdle);

  // rdy gates every update here; outputs are decoded from held state so they hold too.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRstLo;
      src_q   <= SrcReset;
      pc_q    <= '0;
      p_q     <= '0;
      sp_q    <= '0;
      vec_q   <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      if (take) begin
        src_q <= take_src;
        pc_q  <= pc;
        p_q   <= (take_src == SrcBrk) ? (p | PMaskB) : (p & ~PMaskB);
        sp_q  <= sp;
      end else if (state_q == StDone) begin
        src_q <= SrcNone;
      end
      if (cap_lo) vec_q[7:0]  <= bus_rdata;
      if (cap_hi) vec_q[15:8] <= bus_rdata;
    end
  end

  assign busy      = busy_c & ~reset;
  assign bus_we    = we_c & ~reset;
  assign bus_re    = re_c & ~reset;
  assign sp_dec    = sp_dec_c & ~reset;
  assign pc_load   = pc_load_c & ~reset;
  assign set_i     = set_i_c & ~reset;
  assign bus_addr  = reset ? 16'h0000 : addr_c;
  assign bus_wdata = reset ? 8'h00 : wdata_c;
  assign pc_new    = reset ? 16'h0000 : vec_q;
  assign src       = reset ? 3'd0 : src_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Scoreboard bench for irq_sequencer: stimulus queues expected bus cycles,
// a negedge monitor pops and compares whenever the DUT drives the bus.
module tb_irq_sequencer;

  logic        clk = 1'b0;
  logic        reset, rdy, nmi_n, tiq, irq1, irq2, brk_req, boundary, i_flag;
  logic [15:0] pc;
  logic [7:0]  p, sp;
  logic        busy, bus_re, bus_we, sp_dec, pc_load, set_i;
  logic [15:0] bus_addr, pc_new;
  logic [7:0]  bus_wdata, bus_rdata;
  logic [2:0]  src;

  localparam int KW = 0;
  localparam int KR = 1;
  localparam int KL = 2;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] data;
    logic [2:0]  src;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_spdec = 0;

  irq_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .rdy       (rdy),
    .nmi_n     (nmi_n),
    .tiq       (tiq),
    .irq1      (irq1),
    .irq2      (irq2),
    .brk_req   (brk_req),
    .boundary  (boundary),
    .i_flag    (i_flag),
    .pc        (pc),
    .p         (p),
    .sp        (sp),
    .busy      (busy),
    .bus_addr  (bus_addr),
    .bus_re    (bus_re),
    .bus_we    (bus_we),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .sp_dec    (sp_dec),
    .pc_load   (pc_load),
    .pc_new    (pc_new),
    .set_i     (set_i),
    .src       (src)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Vector table: FFF6=A666 FFF8=A888 FFFA=ABAA FFFC=ACCC FFFE=E034.
  always_comb begin
    case (bus_addr)
      16'hFFF6: bus_rdata = 8'h66;
      16'hFFF7: bus_rdata = 8'hA6;
      16'hFFF8: bus_rdata = 8'h88;
      16'hFFF9: bus_rdata = 8'hA8;
      16'hFFFA: bus_rdata = 8'hAA;
      16'hFFFB: bus_rdata = 8'hAB;
      16'hFFFC: bus_rdata = 8'hCC;
      16'hFFFD: bus_rdata = 8'hAC;
      16'hFFFE: bus_rdata = 8'h34;
      16'hFFFF: bus_rdata = 8'hE0;
      default:  bus_rdata = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && rdy) begin
      if (sp_dec) n_spdec++;
      if (bus_we || bus_re || pc_load) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bus_cycle", 64'({bus_we, bus_re, pc_load, bus_addr}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          case (e.kind)
            KW: begin
              chk("wr_strobes", 64'({bus_we, bus_re, sp_dec}), 64'(3'b101));
              chk("wr_addr", 64'(bus_addr), 64'(e.addr));
              chk("wr_data", 64'(bus_wdata), 64'(e.data[7:0]));
            end
            KR: begin
              chk("rd_strobes", 64'({bus_we, bus_re, sp_dec}), 64'(3'b010));
              chk("rd_addr", 64'(bus_addr), 64'(e.addr));
            end
            default: begin
              chk("ld_strobes", 64'({bus_we, bus_re, pc_load, set_i}), 64'(4'b0011));
              chk("ld_pc_new", 64'(pc_new), 64'(e.data));
              chk("ld_src", 64'(src), 64'(e.src));
              chk("ld_latency_cycle", 64'(cyc), 64'(e.cyc));
            end
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_item(input int k, input logic [15:0] a, input logic [15:0] d,
                           input logic [2:0] s, input int c);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    e.src  = s;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Full entry sequence; pp is the hand-computed pushed P, lat the boundary->pc_load cycles.
  task automatic push_seq(input logic [7:0] s, input logic [15:0] pcv, input logic [7:0] pp,
                          input logic [3:0] off, input logic [15:0] vec, input logic [2:0] sr,
                          input int lat);
    logic [7:0] s1, s2;
    s1 = s - 8'd1;
    s2 = s - 8'd2;
    push_item(KW, {8'h21, s},  {8'h00, pcv[15:8]}, 3'd0, 0);
    push_item(KW, {8'h21, s1}, {8'h00, pcv[7:0]},  3'd0, 0);
    push_item(KW, {8'h21, s2}, {8'h00, pp},        3'd0, 0);
    push_item(KR, 16'hFFF0 + {12'h000, off}, 16'h0, 3'd0, 0);
    push_item(KR, 16'hFFF1 + {12'h000, off}, 16'h0, 3'd0, 0);
    push_item(KL, 16'h0, vec, sr, cyc + lat);
  endtask

  task automatic take(input logic [15:0] pcv, input logic [7:0] pv, input logic [7:0] spv);
    pc = pcv;
    p = pv;
    sp = spv;
    boundary = 1'b1;
    chk("busy_before_take", 64'(busy), 64'd0);
    tick();
    boundary = 1'b0;
    brk_req = 1'b0;
    pc = 16'h0;
    p = 8'h0;
    sp = 8'h0;
    chk("busy_after_take", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 60) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_idle"}, 64'(busy), 64'd0);
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string name);
    @(negedge clk);
    chk(name, 64'({busy, bus_we, bus_re, sp_dec, pc_load, set_i, src, bus_wdata}), 64'd0);
    chk({name, "_addr_pc"}, 64'({bus_addr, pc_new}), 64'd0);
  endtask

  initial begin
    reset = 1'b1; rdy = 1'b1; nmi_n = 1'b1; tiq = 1'b0; irq1 = 1'b0; irq2 = 1'b0;
    brk_req = 1'b0; boundary = 1'b0; i_flag = 1'b1; pc = '0; p = '0; sp = '0;
    repeat (3) tick();
    chk_all_zero("reset_state");
    tick();

    // Reset last sampled high in the previous cycle; pc_load lands 3 cycles after that.
    push_item(KR, 16'hFFFE, 16'h0, 3'd0, 0);
    push_item(KR, 16'hFFFF, 16'h0, 3'd0, 0);
    push_item(KL, 16'h0, 16'hE034, 3'd1, cyc + 2);
    n_spdec = 0;
    reset = 1'b0;
    wait_done("reset_seq");
    chk("reset_no_sp_dec", 64'(n_spdec), 64'd0);

    // IRQ1, withdrawn right after take; boundary/BRK while busy must be ignored.
    i_flag = 1'b0; irq1 = 1'b1; n_spdec = 0;
    push_seq(8'hF0, 16'hC123, 8'h04, 4'h8, 16'hA888, 3'd5, 6);
    take(16'hC123, 8'h04, 8'hF0);
    irq1 = 1'b0;
    tick();
    boundary = 1'b1; brk_req = 1'b1;
    tick();
    boundary = 1'b0; brk_req = 1'b0;
    wait_done("irq1");
    chk("irq1_sp_dec_pulses", 64'(n_spdec), 64'd3);

    // NMI + TIQ + IRQ2 with I set: NMI first, B cleared in pushed P.
    i_flag = 1'b1; tiq = 1'b1; irq2 = 1'b1; nmi_n = 1'b0;
    tick();
    push_seq(8'h80, 16'h1234, 8'hEF, 4'hC, 16'hACCC, 3'd2, 6);
    take(16'h1234, 8'hFF, 8'h80);
    nmi_n = 1'b1;
    wait_done("nmi");
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    repeat (2) tick();
    chk("masked_sources_ignored", 64'(busy), 64'd0);
    i_flag = 1'b0;
    push_seq(8'h7E, 16'h5678, 8'h20, 4'hA, 16'hABAA, 3'd4, 6);
    take(16'h5678, 8'h20, 8'h7E);
    tiq = 1'b0;
    wait_done("tiq");

    // IRQ2 with an NMI edge during VEC_HI; NMI taken next even with IRQ2 still high.
    push_seq(8'h40, 16'h9ABC, 8'h00, 4'h6, 16'hA666, 3'd6, 6);
    take(16'h9ABC, 8'h00, 8'h40);
    repeat (4) tick();
    chk("irq2_in_vec_hi", 64'({bus_re, bus_addr}), 64'({1'b1, 16'hFFF7}));
    nmi_n = 1'b0;
    tick();
    nmi_n = 1'b1;
    wait_done("irq2");
    push_seq(8'h3F, 16'h4321, 8'h00, 4'hC, 16'hACCC, 3'd2, 6);
    take(16'h4321, 8'h10, 8'h3F);
    irq2 = 1'b0;
    wait_done("nmi_after_irq2");

    // BRK with I set and SP wrapping 01 -> 00 -> FF; B set in pushed P.
    i_flag = 1'b1; brk_req = 1'b1;
    push_seq(8'h01, 16'h8001, 8'h14, 4'h6, 16'hA666, 3'd3, 6);
    take(16'h8001, 8'h04, 8'h01);
    wait_done("brk");

    // Three stalled cycles in PUSH_L add exactly three cycles of latency.
    i_flag = 1'b0; irq1 = 1'b1; n_spdec = 0;
    push_seq(8'h10, 16'h0102, 8'h00, 4'h8, 16'hA888, 3'd5, 9);
    take(16'h0102, 8'h00, 8'h10);
    irq1 = 1'b0;
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold", 64'({bus_we, bus_addr, bus_wdata}), 64'({1'b1, 16'h210F, 8'h02}));
      tick();
    end
    rdy = 1'b1;
    wait_done("stall");
    chk("stall_sp_dec_pulses", 64'(n_spdec), 64'd3);

    // Reset during PUSH_P aborts; the reset vector fetch follows release.
    irq1 = 1'b1;
    push_item(KW, 16'h2120, 16'h00BE, 3'd0, 0);
    push_item(KW, 16'h211F, 16'h00EF, 3'd0, 0);
    take(16'hBEEF, 8'h01, 8'h20);
    irq1 = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    chk_all_zero("abort_in_push_p");
    tick();
    chk_all_zero("abort_held");
    chk("abort_pushes_seen", 64'(exp_q.size()), 64'd0);
    tick();
    push_item(KR, 16'hFFFE, 16'h0, 3'd0, 0);
    push_item(KR, 16'hFFFF, 16'h0, 3'd0, 0);
    push_item(KL, 16'h0, 16'hE034, 3'd1, cyc + 2);
    reset = 1'b0;
    wait_done("abort_reset_seq");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, got running, required finished");
    $fatal(1, "watchdog timeout");
  end

endmodule
